// File: rtl/dma_write_if.sv
// Memory-bus and TX FIFO signals seen by the DMA write engine.
// master = DMA engine side, slave = arbiter/memory/FIFO side.
interface dma_write_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  mem_request;
  logic                  mem_grant;
  logic [31:0]           mem_addr;
  logic                  tx_enable;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic                  empty;
  logic                  rd_enable;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output mem_request, mem_addr, tx_enable, mem_wr_data, rd_enable,
    input  mem_grant, empty, rd_data
  );

  modport slave (
    input  mem_request, mem_addr, tx_enable, mem_wr_data, rd_enable,
    output mem_grant, empty, rd_data
  );
endinterface

// File: rtl/dma_write_logic.sv
// DMA write engine: pops words from the TX FIFO and writes them to memory
// through the shared-bus arbiter, one word per FETCH/CAPTURE/WRITE round.
module dma_write_logic #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] ADDR_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ctrl_sig_reg,
  input  logic [31:0] addr_reg,
  input  logic [31:0] count_reg,
  dma_write_if.master bus,
  output logic        tx_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUS_REQ = 3'd1,
    FETCH   = 3'd2,
    CAPTURE = 3'd3,
    WRITE   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                state_r;
  state_t                next_s;
  logic [31:0]           cur_addr_r;
  logic [31:0]           cur_count_r;
  logic [DATA_WIDTH-1:0] data_reg_r;
  logic                  inc_dst_r;
  logic                  start_s;
  logic                  unused_ctrl_s;

  assign start_s       = ctrl_sig_reg[0] & ctrl_sig_reg[1];
  assign unused_ctrl_s = ^{ctrl_sig_reg[31:4], ctrl_sig_reg[2]};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s && (count_reg != 32'd0)) begin
          next_s = BUS_REQ;
        end else if (start_s) begin
          next_s = DONE;
        end else begin
          next_s = IDLE;
        end
      end
      BUS_REQ: begin
        if (bus.mem_grant) begin
          next_s = FETCH;
        end else begin
          next_s = BUS_REQ;
        end
      end
      FETCH: begin
        if (bus.mem_grant && !bus.empty) begin
          next_s = CAPTURE;
        end else begin
          next_s = FETCH;
        end
      end
      CAPTURE: next_s = WRITE;
      WRITE: begin
        if (bus.mem_grant && (cur_count_r == 32'd1)) begin
          next_s = DONE;
        end else if (bus.mem_grant) begin
          next_s = FETCH;
        end else begin
          next_s = WRITE;
        end
      end
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Bus and FIFO outputs decoded from state; request stays high for the whole burst
  always_comb begin
    bus.mem_request = 1'b0;
    bus.mem_addr    = 32'd0;
    bus.tx_enable   = 1'b0;
    bus.mem_wr_data = '0;
    bus.rd_enable   = 1'b0;
    case (state_r)
      BUS_REQ, CAPTURE: begin
        bus.mem_request = 1'b1;
      end
      FETCH: begin
        bus.mem_request = 1'b1;
        bus.rd_enable   = bus.mem_grant & ~bus.empty;
      end
      WRITE: begin
        bus.mem_request = 1'b1;
        bus.mem_addr    = cur_addr_r;
        bus.mem_wr_data = data_reg_r;
        bus.tx_enable   = bus.mem_grant;
      end
      default: begin
        bus.mem_request = 1'b0;
      end
    endcase
  end

  // Transfer bookkeeping: address/count/data registers and the sticky done flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_addr_r  <= 32'd0;
      cur_count_r <= 32'd0;
      data_reg_r  <= '0;
      inc_dst_r   <= 1'b0;
      tx_done     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            cur_addr_r  <= addr_reg;
            cur_count_r <= count_reg;
            inc_dst_r   <= ctrl_sig_reg[3];
            tx_done     <= 1'b0;
          end
        end
        CAPTURE: data_reg_r <= bus.rd_data;
        WRITE: begin
          // Without grant everything holds so the popped word is written exactly once
          if (bus.mem_grant) begin
            cur_addr_r  <= inc_dst_r ? (cur_addr_r + ADDR_STEP) : cur_addr_r;
            cur_count_r <= cur_count_r - 32'd1;
          end
        end
        DONE:    tx_done <= 1'b1;
        default: tx_done <= tx_done;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_write_logic.sv
// Directed bench for dma_write_logic: FIFO model, write logger and
// hand-computed expected addresses/data for each scenario.
module tb_dma_write_logic;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ctrl_sig_reg = 32'd0;
  logic [31:0] addr_reg = 32'd0;
  logic [31:0] count_reg = 32'd0;
  logic        tx_done;

  dma_write_if #(.DATA_WIDTH(32)) bus ();

  dma_write_logic #(.DATA_WIDTH(32), .ADDR_STEP(32'd4)) dut (
    .clk          (clk),
    .reset        (reset),
    .ctrl_sig_reg (ctrl_sig_reg),
    .addr_reg     (addr_reg),
    .count_reg    (count_reg),
    .bus          (bus),
    .tx_done      (tx_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // FIFO model: initial block pushes, monitor pops
  logic [31:0] fifo_mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  assign bus.empty = (wr_ptr == rd_ptr);

  // Write log and pop counters, filled by the monitor
  logic [31:0] wr_addr_a [0:63];
  logic [31:0] wr_data_a [0:63];
  int          wr_n = 0;
  int          rd_n = 0;
  int          bad_pop = 0;
  int          cyc = 0;
  int          last_wr_edge = 0;

  initial bus.mem_grant = 1'b0;
  initial bus.rd_data = 32'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.tx_enable) begin
      wr_addr_a[wr_n] <= bus.mem_addr;
      wr_data_a[wr_n] <= bus.mem_wr_data;
      wr_n            <= wr_n + 1;
      last_wr_edge    <= cyc + 1;
    end
    if (bus.rd_enable) begin
      rd_n <= rd_n + 1;
      if (bus.empty) begin
        bad_pop <= bad_pop + 1;
      end else begin
        bus.rd_data <= fifo_mem[rd_ptr];
        rd_ptr      <= rd_ptr + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    fifo_mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  // Apply start for one cycle; returns mem_request seen one cycle later
  task automatic start_xfer(input logic [31:0] c, input logic [31:0] a,
                            input logic [31:0] n, output logic req);
    @(negedge clk);
    ctrl_sig_reg = c;
    addr_reg     = a;
    count_reg    = n;
    @(negedge clk);
    req          = bus.mem_request;
    ctrl_sig_reg = 32'd0;
    addr_reg     = 32'hDEAD_0000;
    count_reg    = 32'd99;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int k;
    k = 0;
    while (tx_done !== 1'b1 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, tx_done}, 32'd1);
  endtask

  task automatic check_wr(input string tag, input int idx,
                          input logic [31:0] a, input logic [31:0] d);
    check({tag, "_addr"}, wr_addr_a[idx], a);
    check({tag, "_data"}, wr_data_a[idx], d);
  endtask

  initial begin
    int   wb, rb, pb, hi, lo;
    logic req;

    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, bus.mem_request}, 32'd0);
    check("rst_txen", {31'd0, bus.tx_enable}, 32'd0);
    check("rst_rden", {31'd0, bus.rd_enable}, 32'd0);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    reset = 1'b1;

    // 1: incrementing burst of three words
    push(32'hAAAA_0001); push(32'hBBBB_0002); push(32'hCCCC_0003);
    bus.mem_grant = 1'b1;
    wb = wr_n; rb = rd_n; pb = bad_pop;
    start_xfer(32'h0B, 32'h1000, 32'd3, req);
    check("t1_latency", {31'd0, req}, 32'd1);
    wait_done("t1_done", 60);
    // tx_done rises on the edge right after the last write edge
    check("t1_done_lat", 32'(cyc - last_wr_edge), 32'd1);
    check("t1_nwr", 32'(wr_n - wb), 32'd3);
    check("t1_nrd", 32'(rd_n - rb), 32'd3);
    check_wr("t1_w0", wb,     32'h1000, 32'hAAAA_0001);
    check_wr("t1_w1", wb + 1, 32'h1004, 32'hBBBB_0002);
    check_wr("t1_w2", wb + 2, 32'h1008, 32'hCCCC_0003);

    // 2: fixed destination address
    push(32'hD000_0000); push(32'hD000_0001); push(32'hD000_0002); push(32'hD000_0003);
    wb = wr_n; rb = rd_n;
    start_xfer(32'h03, 32'h2000, 32'd4, req);
    wait_done("t2_done", 80);
    check("t2_nwr", 32'(wr_n - wb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_wr("t2_w", wb + i, 32'h2000, 32'hD000_0000 + 32'(i));
    end

    // read mode: engine must stay idle and leave the sticky done flag alone
    rb = rd_n; hi = 0;
    @(negedge clk);
    ctrl_sig_reg = 32'h09;
    repeat (4) begin
      @(negedge clk);
      if (bus.mem_request) hi++;
    end
    ctrl_sig_reg = 32'd0;
    check("rdmode_req", 32'(hi), 32'd0);
    check("rdmode_done_sticky", {31'd0, tx_done}, 32'd1);

    // 3: FIFO empty stall
    wb = wr_n; rb = rd_n;
    start_xfer(32'h0B, 32'h3000, 32'd2, req);
    hi = 0; lo = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rd_enable) hi++;
      if (!bus.mem_request) lo++;
    end
    check("t3_rden_empty", 32'(hi), 32'd0);
    check("t3_req_held", 32'(lo), 32'd0);
    check("t3_nrd_stall", 32'(rd_n - rb), 32'd0);
    push(32'hE000_0000); push(32'hE000_0001);
    wait_done("t3_done", 40);
    check("t3_nwr", 32'(wr_n - wb), 32'd2);
    check("t3_nrd", 32'(rd_n - rb), 32'd2);
    check_wr("t3_w0", wb,     32'h3000, 32'hE000_0000);
    check_wr("t3_w1", wb + 1, 32'h3004, 32'hE000_0001);

    // 4: grant lost while the first word sits in WRITE
    push(32'h6000_00A0); push(32'h6000_00A1);
    wb = wr_n; rb = rd_n;
    start_xfer(32'h0B, 32'h6000, 32'd2, req);
    @(negedge clk);
    @(negedge clk);
    bus.mem_grant = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_txen_hold", {31'd0, bus.tx_enable}, 32'd0);
      check("t4_addr_hold", bus.mem_addr, 32'h6000);
      check("t4_data_hold", bus.mem_wr_data, 32'h6000_00A0);
    end
    bus.mem_grant = 1'b1;
    wait_done("t4_done", 40);
    check("t4_nwr", 32'(wr_n - wb), 32'd2);
    check("t4_nrd", 32'(rd_n - rb), 32'd2);
    check_wr("t4_w0", wb,     32'h6000, 32'h6000_00A0);
    check_wr("t4_w1", wb + 1, 32'h6004, 32'h6000_00A1);

    // 5: zero count goes straight to DONE
    wb = wr_n; rb = rd_n;
    start_xfer(32'h0B, 32'h7000, 32'd0, req);
    check("t5_req", {31'd0, req}, 32'd0);
    check("t5_done_cleared", {31'd0, tx_done}, 32'd0);
    @(negedge clk);
    check("t5_done", {31'd0, tx_done}, 32'd1);
    check("t5_nwr", 32'(wr_n - wb), 32'd0);
    check("t5_nrd", 32'(rd_n - rb), 32'd0);

    // 6: reset during the second WRITE of a four-word burst
    push(32'h4444_0000); push(32'h4444_0001); push(32'h4444_0002); push(32'h4444_0003);
    wb = wr_n;
    start_xfer(32'h0B, 32'h4000, 32'd4, req);
    repeat (6) @(negedge clk);
    check("t6_in_write", {31'd0, bus.tx_enable}, 32'd1);
    check("t6_wr_before", 32'(wr_n - wb), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_rst_req", {31'd0, bus.mem_request}, 32'd0);
    check("t6_rst_txen", {31'd0, bus.tx_enable}, 32'd0);
    check("t6_rst_addr", bus.mem_addr, 32'd0);
    check("t6_rst_data", bus.mem_wr_data, 32'd0);
    check("t6_rst_done", {31'd0, tx_done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wb = wr_n;
    start_xfer(32'h0B, 32'h5000, 32'd2, req);
    wait_done("t6_done", 40);
    check("t6_nwr", 32'(wr_n - wb), 32'd2);
    check_wr("t6_w0", wb,     32'h5000, 32'h4444_0002);
    check_wr("t6_w1", wb + 1, 32'h5004, 32'h4444_0003);

    check("pop_while_empty", 32'(bad_pop), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
